// File: rtl/bram_stream_reader.sv
// Burst read engine: walks a synchronous single-port BRAM from a base address and
// presents the words as a valid/ready stream, buffered two deep to hide the read latency.
module bram_stream_reader #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [ADDR_WIDTH:0]   r_length;
  logic [ADDR_WIDTH:0]   r_issued;
  logic                  r_inflight;
  logic                  r_inflight_last;
  logic [DATA_WIDTH-1:0] r_buf [2];
  logic [1:0]            r_buf_last;
  logic                  r_rd_ptr;
  logic                  r_wr_ptr;
  logic [1:0]            r_count;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_issue;
  logic [2:0]            w_occ;

  // Stream handshake: a word moves on a clk edge where m_valid and m_ready are both high;
  // while m_valid is high and m_ready low, m_data and m_last are held unchanged.
  assign w_pop  = (r_count != 2'd0) && m_ready;
  assign w_push = r_inflight;
  // Occupancy after this edge's pop: a pop frees a slot in time for a read issued now.
  assign w_occ  = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = (r_state == S_RUN) && (r_issued < r_length) && (w_occ < 3'd2);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = (length == '0) ? S_FIN : S_RUN;
      S_RUN:   if (r_issued == r_length) w_state_next = S_DRAIN;
      S_DRAIN: if (!r_inflight && ((r_count == 2'd0) || (r_count == 2'd1 && w_pop)))
                 w_state_next = S_FIN;
      S_FIN:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_base          <= '0;
      r_length        <= '0;
      r_issued        <= '0;
      r_mem_addr      <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_buf[0]        <= '0;
      r_buf[1]        <= '0;
      r_buf_last      <= 2'b00;
      r_rd_ptr        <= 1'b0;
      r_wr_ptr        <= 1'b0;
      r_count         <= 2'd0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_IDLE && start) begin
        r_base   <= base_addr;
        r_length <= length;
        r_issued <= '0;
      end
      // Address arithmetic truncates to ADDR_WIDTH, so bursts wrap from the top to 0.
      if (w_issue) begin
        r_mem_addr      <= r_base + r_issued[ADDR_WIDTH-1:0];
        r_issued        <= r_issued + CNT_ONE;
        r_inflight_last <= ((r_issued + CNT_ONE) == r_length);
      end
      r_inflight <= w_issue;
      if (w_push) begin
        r_buf[r_wr_ptr]      <= mem_dout;
        r_buf_last[r_wr_ptr] <= r_inflight_last;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign m_valid   = (r_count != 2'd0);
  assign m_data    = r_buf[r_rd_ptr];
  assign m_last    = m_valid & r_buf_last[r_rd_ptr];
  assign busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done      = (r_state == S_FIN);
  assign mem_we    = 1'b0;
  assign mem_din   = '0;
  assign mem_addr  = r_mem_addr;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader: a table of bursts with hand-computed end words,
// a per-beat expected-data queue, and hand-written reset-abort sequence.
module tb_bram_stream_reader;

  localparam int AW = 13;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          busy;
  logic          done;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic [1:0]    dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  bram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .dbg_state(dbg_state)
  );

  // BRAM whose address register is the engine's registered mem_addr
  logic [DW-1:0] mem [0:(1<<AW)-1];
  assign mem_dout = mem[mem_addr];

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   len;
    int            mode;      // 0: ready=1, 1: ready alternates, 2: ready low clks 5..14
    logic          restart;   // pulse start while busy and during FIN
    logic [DW-1:0] exp_first;
    logic [DW-1:0] exp_lastd;
  } vec_t;

  vec_t vecs[9];

  // ---------------- driver tasks ----------------
  task automatic run_burst(input vec_t v);
    int budget;
    int beats = 0;
    int issued = 0;
    int first_cyc = -1;
    int last_cyc = -1;
    int done_cyc = -1;
    logic [AW-1:0] prev_addr;
    logic held = 1'b0;
    logic held_l = 1'b0;
    logic [DW-1:0] held_d = '0;
    logic [DW-1:0] first_d = '0;
    logic [DW-1:0] last_d = '0;
    logic [DW-1:0] exp_d;
    logic we_seen = 1'b0;
    logic ahead_bad = 1'b0;
    logic stall_bad = 1'b0;
    budget = 3 * int'(v.len) + 40;
    exp_q.delete();
    for (int i = 0; i < int'(v.len); i++)
      exp_q.push_back(32'(((int'(v.base) + i) % (1 << AW)) + 256));
    prev_addr = mem_addr;
    @(negedge clk);
    start = 1'b1; base_addr = v.base; length = v.len; m_ready = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (v.restart && c == 2) begin
        start = 1'b1; base_addr = 13'h300; length = 14'd5;
      end
      if (c == 1) chk("busy_after_start", {63'd0, busy}, {63'd0, v.len != 0});
      if (mem_we !== 1'b0 || mem_din !== '0) we_seen = 1'b1;
      if (mem_addr != prev_addr) begin
        issued++;
        prev_addr = mem_addr;
      end
      if (issued - beats > 2) ahead_bad = 1'b1;
      if (held && !(m_valid === 1'b1 && m_data === held_d && m_last === held_l)) stall_bad = 1'b1;
      if (done) begin
        done_cyc = c;
        if (v.restart) start = 1'b1;
        break;
      end
      case (v.mode)
        0:       m_ready = 1'b1;
        1:       m_ready = c[0];
        default: m_ready = !(c >= 5 && c < 15);
      endcase
      held = 1'b0;
      if (m_valid) begin
        if (m_ready) begin
          if (exp_q.size() == 0) begin
            chk("extra_beat", beats + 1, v.len);
          end else begin
            exp_d = exp_q.pop_front();
            chk("beat_data", m_data, exp_d);
            chk("beat_last", {63'd0, m_last}, {63'd0, exp_q.size() == 0});
          end
          if (beats == 0) begin
            first_cyc = c;
            first_d = m_data;
          end
          last_cyc = c;
          last_d = m_data;
          beats++;
        end else begin
          held = 1'b1; held_d = m_data; held_l = m_last;
        end
      end
    end
    chk("done_seen", {63'd0, done_cyc >= 0}, 64'd1);
    @(negedge clk);
    start = 1'b0;
    chk("done_one_clk", {63'd0, done}, 64'd0);
    chk("busy_after_done", {63'd0, busy}, 64'd0);
    chk("beats", beats, v.len);
    chk("reads_issued", issued, v.len);
    chk("mem_we_zero", {63'd0, we_seen}, 64'd0);
    chk("reads_ahead_le2", {63'd0, ahead_bad}, 64'd0);
    chk("stall_hold", {63'd0, stall_bad}, 64'd0);
    if (v.len != 0) begin
      chk("first_word", first_d, v.exp_first);
      chk("last_word", last_d, v.exp_lastd);
      chk("done_after_last", done_cyc, last_cyc + 1);
      if (v.mode == 0) begin
        chk("first_latency", first_cyc, 3);
        chk("back_to_back", last_cyc - first_cyc, int'(v.len) - 1);
      end
    end else begin
      chk("len0_done_cyc", done_cyc, 1);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
    chk({tag, "_m_valid"}, {63'd0, m_valid}, 64'd0);
    chk({tag, "_m_last"}, {63'd0, m_last}, 64'd0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  task automatic reset_mid_burst();
    logic done_seen = 1'b0;
    @(negedge clk);
    start = 1'b1; base_addr = 13'h020; length = 14'd16; m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_reset_valid", {63'd0, m_valid}, 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle_outputs("abort");
    repeat (6) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    chk("abort_no_done", {63'd0, done_seen}, 64'd0);
    chk("abort_busy_low", {63'd0, busy}, 64'd0);
    m_ready = 1'b0;
  endtask

  // ---------------- main test ----------------
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'(i + 256);
    vecs[0] = '{13'h0004, 14'd3,      0, 1'b0, 32'h104,  32'h106};
    vecs[1] = '{13'h0004, 14'd3,      1, 1'b0, 32'h104,  32'h106};
    vecs[2] = '{13'h1FFE, 14'd4,      0, 1'b0, 32'h20FE, 32'h101};
    vecs[3] = '{13'h0010, 14'd0,      0, 1'b0, 32'h0,    32'h0};
    vecs[4] = '{13'h0030, 14'd8,      2, 1'b0, 32'h130,  32'h137};
    vecs[5] = '{13'h0040, 14'd4,      0, 1'b1, 32'h140,  32'h143};
    vecs[6] = '{13'h0060, 14'd1,      0, 1'b0, 32'h160,  32'h160};
    vecs[7] = '{13'h1000, 14'h2000,   0, 1'b0, 32'h1100, 32'h10FF};
    vecs[8] = '{13'h0050, 14'd2,      0, 1'b0, 32'h150,  32'h151};

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_idle_outputs("reset");
    chk("reset_mem_we", {63'd0, mem_we}, 64'd0);

    for (int i = 0; i < 9; i++) begin
      if (i == 8) reset_mid_burst();
      run_burst(vecs[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
